// File: rtl/uart_prom_loader.sv
// UART boot loader: receives a framed program image and writes it into the prom, holding the core
// in reset until a full image is accepted. Define LOADER_CHECKSUM_EN to require a trailing sum byte.
module uart_prom_loader #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 15,
    parameter int TIMEOUT  = CLK_FREQ / 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              cpu_reset,
    output logic              prom_wr_en,
    output logic [ADDR_W-1:0] prom_wr_addr,
    output logic [DATA_W-1:0] prom_wr_data,
    output logic              load_busy,
    output logic              load_err
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_L, S_LEN_H, S_DATA_L, S_DATA_H,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE, S_ERROR
    } st_t;

    rx_st_t          rx_st_q;
    logic [1:0]      sync_q;
    logic            rx_prev_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            byte_vld_q, frm_err_q;

    st_t             st_q;
    logic [ADDR_W-1:0] len_q, cnt_q;
    logic [7:0]      lo_q;
    logic [TW-1:0]   to_q;
    logic            in_frame;
    logic [ADDR_W-1:0] len_d;

    wire rx_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            rx_prev_q  <= rx_s;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            case (rx_st_q)
                RX_IDLE: if (rx_prev_q && !rx_s) begin
                    rx_cnt_q <= '0;
                    rx_st_q  <= RX_START;
                end
                RX_START: if (rx_cnt_q == CW'(DIV / 2 - 1)) begin
                    // a line already back high at mid start bit was only a glitch
                    rx_st_q  <= rx_s ? RX_IDLE : RX_DATA;
                    rx_cnt_q <= '0;
                    bit_q    <= '0;
                end else rx_cnt_q <= rx_cnt_q + CW'(1);
                RX_DATA: if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_cnt_q <= '0;
                    shift_q  <= {rx_s, shift_q[7:1]};
                    bit_q    <= bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_st_q <= RX_STOP;
                end else rx_cnt_q <= rx_cnt_q + CW'(1);
                RX_STOP: if (rx_cnt_q == CW'(DIV - 1)) begin
                    byte_vld_q <= rx_s;
                    frm_err_q  <= !rx_s;
                    rx_st_q    <= RX_IDLE;
                end else rx_cnt_q <= rx_cnt_q + CW'(1);
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    assign in_frame = (st_q != S_IDLE) && (st_q != S_DONE) && (st_q != S_ERROR);
    assign len_d    = {shift_q[4:0], len_q[7:0]};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sum_q <= '0;
        else if (!in_frame) sum_q <= '0;
        else if (byte_vld_q) sum_q <= sum_q + shift_q;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q         <= S_IDLE;
            cpu_reset    <= 1'b1;
            prom_wr_en   <= 1'b0;
            prom_wr_addr <= '0;
            prom_wr_data <= '0;
            load_busy    <= 1'b0;
            load_err     <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            lo_q         <= '0;
            to_q         <= '0;
        end else begin
            prom_wr_en <= 1'b0;
            if (!in_frame) begin
                if (st_q == S_DONE) begin
                    cpu_reset <= 1'b0;
                    load_busy <= 1'b0;
                end
                if (st_q == S_ERROR) begin
                    cpu_reset <= 1'b1;
                    load_busy <= 1'b0;
                    load_err  <= 1'b1;
                end
                if (byte_vld_q && shift_q == 8'hA5) begin
                    st_q      <= S_LEN_L;
                    cpu_reset <= 1'b1;
                    load_busy <= 1'b1;
                    load_err  <= 1'b0;
                    cnt_q     <= '0;
                    to_q      <= '0;
                end
            end else if (frm_err_q) begin
                st_q <= S_ERROR;
            end else if (!byte_vld_q) begin
                if (to_q == TW'(TIMEOUT - 1)) st_q <= S_ERROR;
                else to_q <= to_q + TW'(1);
            end else begin
                to_q <= '0;
                case (st_q)
                    S_LEN_L: begin
                        len_q <= ADDR_W'(shift_q);
                        st_q  <= S_LEN_H;
                    end
                    S_LEN_H: begin
                        len_q <= len_d;
                        st_q  <= (shift_q[7:5] != 3'd0 || len_d == '0) ? S_ERROR : S_DATA_L;
                    end
                    S_DATA_L: begin
                        lo_q <= shift_q;
                        st_q <= S_DATA_H;
                    end
                    S_DATA_H: begin
                        prom_wr_en   <= 1'b1;
                        prom_wr_addr <= cnt_q;
                        prom_wr_data <= DATA_W'({shift_q[6:0], lo_q});
                        cnt_q        <= cnt_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        st_q <= (cnt_q == len_q - ADDR_W'(1)) ? S_CHK : S_DATA_L;
                    end
                    S_CHK: begin
                        st_q <= (sum_q + shift_q == 8'h00) ? S_DONE : S_ERROR;
`else
                        st_q <= (cnt_q == len_q - ADDR_W'(1)) ? S_DONE : S_DATA_L;
`endif
                    end
                    default: st_q <= S_ERROR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_prom_loader.sv
// Directed bench for uart_prom_loader at a reduced bit rate (16 clocks per bit); follows
// LOADER_CHECKSUM_EN to decide whether frames carry a trailing sum byte.
module tb_uart_prom_loader;
    localparam int DIV = 16;
    localparam int TO  = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        cpu_reset, prom_wr_en, load_busy, load_err;
    logic [12:0] prom_wr_addr;
    logic [14:0] prom_wr_data;

    int nvec = 0, nfail = 0, nwr = 0, base;
    logic [12:0] wa [0:31];
    logic [14:0] wd [0:31];

    uart_prom_loader #(.CLK_FREQ(1_600_000), .BAUD(100_000), .ADDR_W(13), .DATA_W(15),
                       .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .cpu_reset(cpu_reset),
        .prom_wr_en(prom_wr_en), .prom_wr_addr(prom_wr_addr), .prom_wr_data(prom_wr_data),
        .load_busy(load_busy), .load_err(load_err));

    always #5 clk = ~clk;

    always @(negedge clk) if (prom_wr_en && nwr < 32) begin
        wa[nwr] = prom_wr_addr;
        wd[nwr] = prom_wr_data;
        nwr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bitc(input logic v);
        uart_rx = v;
        repeat (DIV) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        bitc(1'b0);
        for (int i = 0; i < 8; i++) bitc(b[i]);
        bitc(1'b1);
        repeat (4) @(posedge clk);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [12:0] a, input logic [14:0] d);
        chk({tag, "_addr"}, 32'(wa[idx]), 32'(a));
        chk({tag, "_data"}, 32'(wd[idx]), 32'(d));
    endtask

    initial begin
        // 1: reset values and idle line
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_wr_en",     32'(prom_wr_en), 32'd0);
        chk("rst_addr",      32'(prom_wr_addr), 32'd0);
        chk("rst_data",      32'(prom_wr_data), 32'd0);
        chk("rst_busy",      32'(load_busy), 32'd0);
        chk("rst_err",       32'(load_err), 32'd0);
        reset = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("idle_busy",      32'(load_busy), 32'd0);
        chk("idle_nwr",       32'(nwr), 32'd0);

        // 2: two-word good frame
        base = nwr;
        send(8'hA5);
        @(negedge clk);
        chk("c2_busy_mid", 32'(load_busy), 32'd1);
        send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'hFF); send(8'h7F);
`ifdef LOADER_CHECKSUM_EN
        send(8'h3A);
`endif
        @(negedge clk);
        chk("c2_nwr", 32'(nwr - base), 32'd2);
        chk_wr("c2_w0", base, 13'd0, 15'h1234);
        chk_wr("c2_w1", base + 1, 13'd1, 15'h7FFF);
        chk("c2_hold_addr", 32'(prom_wr_addr), 32'd1);
        chk("c2_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("c2_err", 32'(load_err), 32'd0);
        chk("c2_busy", 32'(load_busy), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // 3: same frame, bad sum
        base = nwr;
        send(8'hA5); send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'hFF); send(8'h7F);
        send(8'h3B);
        @(negedge clk);
        chk("c3_nwr", 32'(nwr - base), 32'd2);
        chk("c3_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("c3_err", 32'(load_err), 32'd1);
`endif

        // 4: truncated frame times out after one word
        base = nwr;
        send(8'hA5); send(8'h03); send(8'h00); send(8'h11); send(8'h22);
        repeat (TO + 50) @(posedge clk);
        @(negedge clk);
        chk("c4_nwr", 32'(nwr - base), 32'd1);
        chk_wr("c4_w0", base, 13'd0, 15'h2211);
        chk("c4_err", 32'(load_err), 32'd1);
        chk("c4_busy", 32'(load_busy), 32'd0);
        chk("c4_cpu_reset", 32'(cpu_reset), 32'd1);
        base = nwr;
        send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'h55);
`endif
        @(negedge clk);
        chk("c4b_nwr", 32'(nwr - base), 32'd1);
        chk_wr("c4b_w0", base, 13'd0, 15'h00AA);
        chk("c4b_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("c4b_err", 32'(load_err), 32'd0);

        // 5: zero length, then a short glitch inside a frame must not count as a byte
        base = nwr;
        send(8'hA5); send(8'h00); send(8'h00);
        @(negedge clk);
        chk("c5_nwr", 32'(nwr - base), 32'd0);
        chk("c5_err", 32'(load_err), 32'd1);
        chk("c5_cpu_reset", 32'(cpu_reset), 32'd1);
        base = nwr;
        send(8'hA5);
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        uart_rx = 1'b1;
        repeat (32) @(posedge clk);
        send(8'h01); send(8'h00); send(8'hAA); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'h55);
`endif
        @(negedge clk);
        chk("c5g_nwr", 32'(nwr - base), 32'd1);
        chk_wr("c5g_w0", base, 13'd0, 15'h00AA);
        chk("c5g_cpu_reset", 32'(cpu_reset), 32'd0);

        // 6: reload after a good load, then reset mid-frame
        base = nwr;
        send(8'hA5);
        @(negedge clk);
        chk("c6_cpu_reset_hi", 32'(cpu_reset), 32'd1);
        chk("c6_busy", 32'(load_busy), 32'd1);
        send(8'h01); send(8'h00); send(8'hAA); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'h55);
`endif
        @(negedge clk);
        chk("c6_nwr", 32'(nwr - base), 32'd1);
        chk_wr("c6_w0", base, 13'd0, 15'h00AA);
        chk("c6_cpu_reset_lo", 32'(cpu_reset), 32'd0);
        base = nwr;
        send(8'hA5); send(8'h01); send(8'h00); send(8'hAA);
        @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("c6r_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("c6r_wr_en", 32'(prom_wr_en), 32'd0);
        chk("c6r_addr", 32'(prom_wr_addr), 32'd0);
        chk("c6r_data", 32'(prom_wr_data), 32'd0);
        chk("c6r_busy", 32'(load_busy), 32'd0);
        chk("c6r_err", 32'(load_err), 32'd0);
        repeat (2) @(posedge clk);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("c6r_nwr", 32'(nwr - base), 32'd0);
        chk("c6r_busy_after", 32'(load_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
